// File: rtl/hilo_muldiv_unit.sv
// HI/LO accumulator with multiply/divide engine for the EX stage; divide is iterative restoring.
// Optional macro HILO_ITER_MUL_EN replaces the single-cycle multiplier with a shift-add sequence.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ReadHi,
    output logic [WIDTH-1:0] ReadLo
);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_MADD  = 4'd2;
    localparam logic [3:0] OP_MADDU = 4'd3;
    localparam logic [3:0] OP_MSUB  = 4'd4;
    localparam logic [3:0] OP_MSUBU = 4'd5;
    localparam logic [3:0] OP_DIV   = 4'd6;
    localparam logic [3:0] OP_DIVU  = 4'd7;
    localparam logic [3:0] OP_MTHI  = 4'd8;
    localparam logic [3:0] OP_MTLO  = 4'd9;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DIV_RUN = 3'd1,
        S_DIV_FIX = 3'd2
`ifdef HILO_ITER_MUL_EN
        , S_MUL_RUN = 3'd3,
        S_MUL_FIX = 3'd4
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d, a_q, a_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic             a_neg_q, a_neg_d, b_neg_q, b_neg_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH:0]   trial_s;

    // kind = Op[3:1]: 0 plain product, 1 accumulate, 2 subtract from HI/LO
    function automatic logic [2*WIDTH-1:0] hilo_acc(input logic [2:0] kind,
                                                    input logic [2*WIDTH-1:0] p,
                                                    input logic [2*WIDTH-1:0] hilo);
        case (kind)
            3'd1:    return hilo + p;
            3'd2:    return hilo - p;
            default: return p;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign trial_s = {rem_q, quo_q[WIDTH-1]} - {1'b0, div_q};

`ifdef HILO_ITER_MUL_EN
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] mprod_s;
    assign sum_s   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, div_q} : {(WIDTH+1){1'b0}});
    assign mprod_s = (a_neg_q ^ b_neg_q) ? -{rem_q, quo_q} : {rem_q, quo_q};
`else
    logic [2*WIDTH-1:0] ext_a_s, ext_b_s, prod_s;
    // Sign-extend to 2*WIDTH so one unsigned multiplier yields the signed product modulo 2^(2*WIDTH)
    assign ext_a_s = {{WIDTH{~Op[0] & A[WIDTH-1]}}, A};
    assign ext_b_s = {{WIDTH{~Op[0] & B[WIDTH-1]}}, B};
    assign prod_s  = ext_a_s * ext_b_s;
`endif

    // State and datapath registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            quo_q   <= {WIDTH{1'b0}};
            div_q   <= {WIDTH{1'b0}};
            a_q     <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            op_q    <= 4'd0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        a_d     = a_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    op_d    = Op;
                    a_d     = A;
                    a_neg_d = ~Op[0] & A[WIDTH-1];
                    b_neg_d = ~Op[0] & B[WIDTH-1];
                    case (Op)
                        OP_MTHI: begin
                            hi_d   = A;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = A;
                            done_d = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            rem_d   = {WIDTH{1'b0}};
                            quo_d   = mag(A, ~Op[0] & A[WIDTH-1]);
                            div_d   = mag(B, ~Op[0] & B[WIDTH-1]);
                            cnt_d   = {CNT_W{1'b0}};
                            busy_d  = 1'b1;
                            state_d = S_DIV_RUN;
                        end
                        OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
`ifdef HILO_ITER_MUL_EN
                            rem_d   = {WIDTH{1'b0}};
                            quo_d   = mag(B, ~Op[0] & B[WIDTH-1]);
                            div_d   = mag(A, ~Op[0] & A[WIDTH-1]);
                            cnt_d   = {CNT_W{1'b0}};
                            busy_d  = 1'b1;
                            state_d = S_MUL_RUN;
`else
                            {hi_d, lo_d} = hilo_acc(Op[3:1], prod_s, {hi_q, lo_q});
                            done_d       = 1'b1;
`endif
                        end
                        default: done_d = 1'b1;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DIV_RUN: begin
                if (!trial_s[WIDTH]) begin
                    rem_d = trial_s[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DIV_FIX;
                end else begin
                    state_d = S_DIV_RUN;
                end
            end
            S_DIV_FIX: begin
                // Divide by zero reports the raw dividend rather than the sign-fixed magnitude
                if (div_q == {WIDTH{1'b0}}) begin
                    hi_d = a_q;
                    lo_d = {WIDTH{1'b1}};
                end else begin
                    hi_d = mag(rem_q, a_neg_q);
                    lo_d = mag(quo_q, a_neg_q ^ b_neg_q);
                end
                cnt_d   = {CNT_W{1'b0}};
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
`ifdef HILO_ITER_MUL_EN
            S_MUL_RUN: begin
                rem_d = sum_s[WIDTH:1];
                quo_d = {sum_s[0], quo_q[WIDTH-1:1]};
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == LAST_CNT) begin
                    state_d = S_MUL_FIX;
                end else begin
                    state_d = S_MUL_RUN;
                end
            end
            S_MUL_FIX: begin
                {hi_d, lo_d} = hilo_acc(op_q[3:1], mprod_s, {hi_q, lo_q});
                cnt_d   = {CNT_W{1'b0}};
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
`endif
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign Busy   = busy_q;
    assign Done   = done_q;
    assign ReadHi = hi_q;
    assign ReadLo = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: random and directed ops against an arithmetic reference model.
module tb_hilo_muldiv_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [3:0]  Op = 4'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        Busy, Done;
    logic [31:0] ReadHi, ReadLo;

    hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .Busy(Busy), .Done(Done), .ReadHi(ReadHi), .ReadLo(ReadLo)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

`ifdef HILO_ITER_MUL_EN
    localparam int MUL_LAT = 33;
`else
    localparam int MUL_LAT = 0;
`endif

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: update HI/LO from the instruction semantics, return result latency
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        logic signed [63:0] sa, sb;
        logic [63:0] p, acc;
        lat = 0;
        acc = {m_hi, m_lo};
        if (op <= 4'd5) begin
            if (op[0]) p = {32'd0, a} * {32'd0, b};
            else begin
                sa = $signed(a);
                sb = $signed(b);
                p  = sa * sb;
            end
            if (op[3:1] == 3'd0) acc = p;
            else if (op[3:1] == 3'd1) acc = acc + p;
            else acc = acc - p;
            {m_hi, m_lo} = acc;
            lat = MUL_LAT;
        end else if (op == 4'd6 || op == 4'd7) begin
            lat = 33;
            if (b == 32'd0) begin
                m_hi = a;
                m_lo = 32'hFFFF_FFFF;
            end else if (op == 4'd7) begin
                m_lo = a / b;
                m_hi = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                m_lo = 32'h8000_0000;
                m_hi = 32'd0;
            end else begin
                m_lo = $signed(a) / $signed(b);
                m_hi = $signed(a) % $signed(b);
            end
        end else if (op == 4'd8) m_hi = a;
        else if (op == 4'd9) m_lo = a;
    endtask

    // Called just after a falling edge; returns at the falling edge following E0
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int   g = 0;
        int   lat;
        exp_t e;
        while (Busy && g < 200) begin
            @(negedge Clk);
            g++;
        end
        if (Busy) chk("busy_timeout", {31'd0, Busy}, 32'd0);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        e.cyc = cyc + 1;
        model(op, a, b, lat);
        e.cyc = e.cyc + lat;
        e.hi  = m_hi;
        e.lo  = m_lo;
        sbq.push_back(e);
        @(negedge Clk);
        Start = 1'b0;
        chk("busy_after_e0", {31'd0, Busy}, {31'd0, (lat != 0)});
    endtask

    // Monitor: every Done must match the oldest expected result, value and cycle
    always @(negedge Clk) begin
        exp_t e;
        if (!Reset && Done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", {31'd0, Done}, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("hi", ReadHi, e.hi);
                chk("lo", ReadLo, e.lo);
                chk("done_cycle", cyc, e.cyc);
                chk("busy_at_done", {31'd0, Busy}, 32'd0);
            end
        end
    end

    task automatic do_reset_check();
        sbq.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        chk("rst_hi", ReadHi, 32'd0);
        chk("rst_lo", ReadLo, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
    endtask

    task automatic drain();
        int g = 0;
        while (sbq.size() != 0 && g < 200) begin
            @(negedge Clk);
            g++;
        end
        chk("drain_timeout", sbq.size(), 32'd0);
        @(negedge Clk);
    endtask

    initial begin
        logic [31:0] specials [6];
        logic [31:0] ra, rb;
        logic [3:0]  rop;
        specials[0] = 32'd0;
        specials[1] = 32'h8000_0000;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'd1;
        specials[4] = 32'h7FFF_FFFF;
        specials[5] = 32'd2;

        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        do_reset_check();

        // MULT of a small negative, then MTHI/MTLO/MADDU carry into HI
        issue(4'd0, 32'hFFFF_FFFD, 32'd7);
        issue(4'd8, 32'hFF00_FF00, 32'd0);
        issue(4'd9, 32'h00FF_00FF, 32'd0);
        issue(4'd3, 32'h0001_0000, 32'h0001_0000);
        drain();

        // Async reset mid-idle, between clock edges
        #2 Reset = 1'b1;
        #1 do_reset_check();
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        // MSUBU wraps below zero, MADD restores it
        issue(4'd5, 32'd1, 32'd1);
        issue(4'd2, 32'd1, 32'd1);
        drain();

        // Signed divide with an ignored MTLO attempt while busy
        issue(4'd6, 32'hFFFF_FFF9, 32'd2);
        repeat (4) @(negedge Clk);
        Start = 1'b1;
        Op    = 4'd9;
        A     = 32'h1234_5678;
        @(negedge Clk);
        Start = 1'b0;
        drain();

        // Divide by zero, then a divide aborted by reset
        issue(4'd7, 32'd5, 32'd0);
        issue(4'd7, 32'd100, 32'd7);
        repeat (9) @(negedge Clk);
        #2 Reset = 1'b1;
        #1 do_reset_check();
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (40) @(negedge Clk);

        // MIN / -1 and reserved opcodes
        issue(4'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(4'd12, 32'hDEAD_BEEF, 32'd3);
        drain();

        // Randomized back-to-back traffic
        for (int i = 0; i < 150; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 2) == 0) rb = rb & 32'h0000_00FF;
            issue(rop, ra, rb);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
